// File: rtl/otter_hazard_unit.sv
// ---------------------------------------------------------------------------
// otter_hazard_unit
//
// Hazard detection and operand forwarding control for the pipelined OTTER
// core. A DEPTH-entry shift table follows every instruction that left decode
// (entry 0 = EX, entry DEPTH-1 = WB). Each entry remembers whether it holds a
// register-writing instruction, its destination and whether it is a LOAD.
// The unit compares the ID-stage source registers against the table. It then
// produces the decode stall (which also means "issue a bubble into EX") and a
// forwarding select for each operand.
//
// Build option:
//   OTTER_FWD_EN  defined   -> results are forwarded from the table.
//                 undefined -> no forwarding; any pending writer stalls ID
//                              until it has left WB, and the selects read 0.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   id_valid             a real instruction sits in ID
//   id_rs1/rs2_addr      source register addresses in ID
//   id_rs1/rs2_used      the source is actually read
//   id_rd_addr           destination register in ID
//   id_rd_used           the instruction writes the register file
//   id_is_load           the instruction is a LOAD
//   flush                branch/jump taken in EX, ID instruction is dead
//   stall                hold PC and IF/ID, insert a bubble into EX
//   fwd_sel_a/b          0 = register file, k = result held in entry k-1
//   stall_count          saturating count of stalled cycles
// ---------------------------------------------------------------------------
module otter_hazard_unit #(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]         id_rs2_addr,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [REG_ADDR_W-1:0]         id_rd_addr,
    input  logic                          id_rd_used,
    input  logic                          id_is_load,
    input  logic                          flush,
    output logic                          stall,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_a,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_b,
    output logic [CNT_W-1:0]              stall_count
);

    localparam int FSW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      load_q,  load_d;
    logic [REG_ADDR_W-1:0] rd_q [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;

    logic useA, useB;
    logic hazA, hazB;
    logic issue;

    // x0 is hardwired to zero, so it is never a real dependency.
    assign useA = id_valid & id_rs1_used & (id_rs1_addr != '0);
    assign useB = id_valid & id_rs2_used & (id_rs2_addr != '0);

`ifdef OTTER_FWD_EN
    logic [FSW-1:0] selA, selB;

    // The scan runs from oldest to youngest, so the youngest matching
    // producer is the one that decides the result. A load that has not yet
    // reached the MEM output register cannot be forwarded, so it stalls.
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        selA = '0;
        selB = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (valid_q[k] && (rd_q[k] != '0)) begin
                if (useA && (rd_q[k] == id_rs1_addr)) begin
                    if (load_q[k] && (k < LOAD_READY)) begin
                        hazA = 1'b1;
                        selA = '0;
                    end else begin
                        hazA = 1'b0;
                        selA = FSW'(k + 1);
                    end
                end
                if (useB && (rd_q[k] == id_rs2_addr)) begin
                    if (load_q[k] && (k < LOAD_READY)) begin
                        hazB = 1'b1;
                        selB = '0;
                    end else begin
                        hazB = 1'b0;
                        selB = FSW'(k + 1);
                    end
                end
            end
        end
    end

    assign fwd_sel_a = selA;
    assign fwd_sel_b = selB;
`else
    logic unusedLoadInfo;

    // Without forwarding, any pending writer of a source register blocks ID.
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[k] && (rd_q[k] != '0)) begin
                if (useA && (rd_q[k] == id_rs1_addr)) hazA = 1'b1;
                if (useB && (rd_q[k] == id_rs2_addr)) hazB = 1'b1;
            end
        end
    end

    assign fwd_sel_a      = '0;
    assign fwd_sel_b      = '0;
    assign unusedLoadInfo = (^load_q) ^ (LOAD_READY != 0);
`endif

    // A flushed ID instruction is dead, so it never stalls and never issues.
    assign stall = (hazA | hazB) & ~flush;
    assign issue = id_valid & id_rd_used & ~stall & ~flush;

    // Next table state: a new entry (or a bubble) enters EX and everything
    // else moves one stage down. The WB entry drops off the end.
    always_comb begin
        valid_d  = {valid_q[DEPTH-2:0], issue};
        load_d   = {load_q[DEPTH-2:0], issue & id_is_load};
        rd_d[0]  = issue ? id_rd_addr : '0;
        for (int i = 1; i < DEPTH; i++) begin
            rd_d[i] = rd_q[i-1];
        end
        count_d = count_q;
        if (stall && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            load_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    assign stall_count = count_q;

endmodule

// File: doc/otter_hazard_unit.md
# otter_hazard_unit

Parametrised hazard and forwarding controller for the pipelined OTTER core. It tracks in-flight destination registers in a DEPTH-entry shift table that mirrors the post-decode pipeline stages (EX, MEM, WB by default). It drives the decode-stage stall, the bubble insertion, and per-operand forwarding selects. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- DEPTH, 3: post-decode stages tracked; entry 0 = EX, entry DEPTH-1 = WB; legal range 2..8
- REG_ADDR_W, 5: register address width
- LOAD_READY, 2: first entry index whose load data is forwardable (2 = MEM-output register); legal range 1..DEPTH-1
- CNT_W, 32: stall counter width

Ports (FSW = $clog2(DEPTH+1)):
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- id_valid  in  1  a real instruction occupies ID
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source addresses in ID
- id_rs1_used, id_rs2_used  in  1  source actually read by the instruction
- id_rd_addr  in  REG_ADDR_W  destination in ID
- id_rd_used  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a LOAD
- flush  in  1  taken branch/jump resolved in EX; kills the ID instruction
- stall  out  1  hold PC and IF/ID register; insert a bubble into EX
- fwd_sel_a, fwd_sel_b  out  FSW  0 = register file, k = result of entry k-1
- stall_count  out  CNT_W  number of cycles with stall asserted (saturating)

## Operation
- Table entry fields: valid, rd, is_load. Only entries with valid=1 and rd≠0 participate in hazard checks.
- Issue condition: issue = id_valid & id_rd_used & ~stall & ~flush.
- Per cycle, entry[0] <= issue ? {1, id_rd_addr, id_is_load} : bubble (valid=0). For i≥1, entry[i] <= entry[i-1]. Entry DEPTH-1 falls off after one cycle.
- Hazard search runs per operand, only when the operand is used, its address is nonzero, and id_valid=1. The search scans entries 0..DEPTH-1, and the lowest matching index (youngest) wins.
- Forwarding operand result: no match gives sel=0 and no hazard. A match at k gives sel=k+1. The exception is a match with entry[k].is_load and k<LOAD_READY: that is a hazard and sel=0.
- stall = hazard_a | hazard_b, gated to 0 when flush=1. Flush has priority, because the ID instruction is dead.
- When stall=1, sel outputs still reflect the search. Downstream ignores them because a bubble is issued.
- stall_count increments by 1 each cycle stall=1. It holds at 2^CNT_W-1.
- No internal FSM beyond the table. Behaviour is fully determined by the table plus ID inputs.

## Timing
- stall, fwd_sel_a and fwd_sel_b are combinational from the current table and ID inputs. They are valid in the same cycle the instruction sits in ID.
- Table and counter update on the rising edge of CLK.
- Load-use latency with defaults: a dependent instruction directly after a LOAD stalls exactly 2 cycles. On the first cycle the load is in entry0; on the second it is in entry1. On the third cycle sel=3 (load in entry2).
- A dependent ALU instruction directly after a producer gets sel=1 with zero stall.
- Reset: all entries valid=0, stall=0 (absent new ID hazards, since the table is empty), fwd_sel_a/b=0, stall_count=0.
- RST asserted mid-stall clears the table on the next edge. The stall drops once the table is empty.
- Simultaneous flush and hazard: stall=0, a bubble enters entry0, and the counter does not increment.
- Simultaneous writes to the same rd in several entries: the youngest entry is forwarded.

## Configuration
- OTTER_FWD_EN defined: forwarding behaviour as described above.
- OTTER_FWD_EN undefined: fwd_sel_a and fwd_sel_b are tied to 0. Any valid match in any entry, including WB, is a hazard. The dependent instruction waits until the producer has left entry DEPTH-1, which is 3 stall cycles after an adjacent producer at default DEPTH.

## Test plan
- Reset: hold RST 2 cycles with id_valid=1, rs1=5 -> stall=0, sel=0, stall_count=0 after release.
- ALU chain: addi x5 then add x6,x5,x5 back-to-back -> second instruction sees fwd_sel_a=fwd_sel_b=1 and stall=0. With OTTER_FWD_EN off -> 3 stall cycles, then sel=0.
- Load-use: lw x7 then add x8,x7,x0 -> stall=1 for 2 cycles, then fwd_sel_a=3, fwd_sel_b=0, stall_count=2.
- x0 and unused operands: lw x0 then add using x0, and rs2_used=0 with rs2=7 after lw x7 -> stall=0, sel=0.
- Flush priority: hazardous ID instruction with flush=1 -> stall=0, entry0 becomes a bubble, stall_count unchanged.
- Youngest wins and saturation: addi x5; addi x5; add x9,x5 -> fwd_sel_a=1. With CNT_W=2 and 5 stall cycles -> stall_count=3.
